// File: rtl/prog_mealy_pkg.sv
// Shared helpers for the programmable Mealy machine: state width and
// the self-loop value each table row holds out of reset.
package prog_mealy_pkg;

  function automatic int st_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Row s resets to "stay in s"; 16 states max, so 4 bits always suffice.
  function automatic logic [3:0] rst_next(input int s);
    return s[3:0];
  endfunction

endpackage

// File: rtl/mealy_tbl.sv
// Flop-based transition/output table with a checked write port and a
// combinational read port indexed by the current state and input symbol.
module mealy_tbl
  import prog_mealy_pkg::*;
#(
  parameter int NUM_STATES = 5,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1,
  parameter int ST_W       = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [ST_W-1:0]  wr_state_i,
  input  logic [IN_W-1:0]  wr_sym_i,
  input  logic [ST_W-1:0]  wr_next_i,
  input  logic [OUT_W-1:0] wr_out_i,
  output logic             wr_err_o,
  input  logic [ST_W-1:0]  rd_state_i,
  input  logic [IN_W-1:0]  rd_sym_i,
  output logic             rd_ok_o,
  output logic [ST_W-1:0]  rd_next_o,
  output logic [OUT_W-1:0] rd_out_o
);

  localparam int NSYM = 2 ** IN_W;
  localparam logic [ST_W:0] NS = (ST_W + 1)'(NUM_STATES);

  logic [ST_W-1:0]  nxt_q [NUM_STATES][NSYM];
  logic [OUT_W-1:0] out_q [NUM_STATES][NSYM];
  logic [ST_W-1:0]  rst_nxt [NUM_STATES];
  logic             wr_ok;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_rst
    localparam logic [3:0] RN = rst_next(s);
    assign rst_nxt[s] = RN[ST_W-1:0];
  end

  assign wr_ok    = we_i && ({1'b0, wr_state_i} < NS) && ({1'b0, wr_next_i} < NS);
  assign wr_err_o = we_i && !wr_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        for (int x = 0; x < NSYM; x++) begin
          nxt_q[s][x] <= rst_nxt[s];
          out_q[s][x] <= '0;
        end
      end
    end else if (wr_ok) begin
      nxt_q[wr_state_i][wr_sym_i] <= wr_next_i;
      out_q[wr_state_i][wr_sym_i] <= wr_out_i;
    end
  end

  // An out-of-range state reads as zero; the top treats it as a fault.
  always_comb begin
    rd_ok_o   = ({1'b0, rd_state_i} < NS);
    rd_next_o = '0;
    rd_out_o  = '0;
    if (rd_ok_o) begin
      rd_next_o = nxt_q[rd_state_i][rd_sym_i];
      rd_out_o  = out_q[rd_state_i][rd_sym_i];
    end
  end

endmodule

// File: rtl/prog_mealy_fsm.sv
// Runtime-programmable Mealy machine: registered state/output stepped by
// ctrl_in, loadable start state, table written through the cfg port.
module prog_mealy_fsm
  import prog_mealy_pkg::*;
#(
  parameter int NUM_STATES = 5,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1,
  localparam int ST_W      = st_width(NUM_STATES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  sw_in,
  input  logic             ctrl_in,
  input  logic             load_en,
  input  logic [ST_W-1:0]  state_in,
  input  logic             cfg_we,
  input  logic [ST_W-1:0]  cfg_state,
  input  logic [IN_W-1:0]  cfg_sym,
  input  logic [ST_W-1:0]  cfg_next,
  input  logic [OUT_W-1:0] cfg_out,
  output logic [ST_W-1:0]  state,
  output logic [OUT_W-1:0] out,
  output logic             step_vld,
  output logic             err
);

  localparam logic [ST_W:0] NS = (ST_W + 1)'(NUM_STATES);

  logic [ST_W-1:0]  state_q, state_d, tbl_next;
  logic [OUT_W-1:0] out_q, out_d, tbl_out;
  logic             step_q, step_d, err_q, err_d;
  logic             cur_ok, wr_err, load_ok;

  mealy_tbl #(
    .NUM_STATES (NUM_STATES),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .ST_W       (ST_W)
  ) u_tbl (
    .clk        (clk),
    .reset_n    (reset_n),
    .we_i       (cfg_we),
    .wr_state_i (cfg_state),
    .wr_sym_i   (cfg_sym),
    .wr_next_i  (cfg_next),
    .wr_out_i   (cfg_out),
    .wr_err_o   (wr_err),
    .rd_state_i (state_q),
    .rd_sym_i   (sw_in),
    .rd_ok_o    (cur_ok),
    .rd_next_o  (tbl_next),
    .rd_out_o   (tbl_out)
  );

  assign load_ok = ({1'b0, state_in} < NS);

  // Load beats step; a write landing on the stepped entry is seen next cycle
  // because the lookup reads the flops before the edge.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    step_d  = 1'b0;
    err_d   = wr_err;
    if (load_en) begin
      if (load_ok) state_d = state_in;
      else         err_d   = 1'b1;
    end else if (ctrl_in) begin
      if (cur_ok) begin
        state_d = tbl_next;
        out_d   = tbl_out;
        step_d  = 1'b1;
      end else begin
        state_d = '0;
        out_d   = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
      out_q   <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign state    = state_q;
  assign out      = out_q;
  assign step_vld = step_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Directed scenarios plus random traffic against an array-based model of
// the programmable Mealy machine.
module tb_prog_mealy_fsm;

  localparam int NS   = 5;
  localparam int NSYM = 4;

  logic       clk;
  logic       reset_n;
  logic [1:0] sw_in;
  logic       ctrl_in;
  logic       load_en;
  logic [2:0] state_in;
  logic       cfg_we;
  logic [2:0] cfg_state;
  logic [1:0] cfg_sym;
  logic [2:0] cfg_next;
  logic [0:0] cfg_out;
  logic [2:0] state;
  logic [0:0] out;
  logic       step_vld;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;

  int m_next [NS][NSYM];
  int m_out  [NS][NSYM];
  int m_state;
  int m_o;

  prog_mealy_fsm #(.NUM_STATES(5), .IN_W(2), .OUT_W(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .ctrl_in   (ctrl_in),
    .load_en   (load_en),
    .state_in  (state_in),
    .cfg_we    (cfg_we),
    .cfg_state (cfg_state),
    .cfg_sym   (cfg_sym),
    .cfg_next  (cfg_next),
    .cfg_out   (cfg_out),
    .state     (state),
    .out       (out),
    .step_vld  (step_vld),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int s = 0; s < NS; s++)
      for (int x = 0; x < NSYM; x++) begin
        m_next[s][x] = s;
        m_out[s][x]  = 0;
      end
    m_state = 0;
    m_o     = 0;
  endtask

  // One clock: drive inputs, predict, then compare just after the edge.
  task automatic cyc(input int ld, input int sti, input int ct, input int sw,
                     input int we, input int cs, input int cx, input int cn,
                     input int co);
    int e_err, e_step, nx;
    load_en   = (ld != 0);
    state_in  = sti[2:0];
    ctrl_in   = (ct != 0);
    sw_in     = sw[1:0];
    cfg_we    = (we != 0);
    cfg_state = cs[2:0];
    cfg_sym   = cx[1:0];
    cfg_next  = cn[2:0];
    cfg_out   = co[0:0];
    e_err  = 0;
    e_step = 0;
    if (ld != 0) begin
      if (sti < NS) m_state = sti;
      else          e_err   = 1;
    end else if (ct != 0) begin
      nx      = m_next[m_state][sw];
      m_o     = m_out[m_state][sw];
      m_state = nx;
      e_step  = 1;
    end
    if (we != 0) begin
      if (cs < NS && cn < NS) begin
        m_next[cs][cx] = cn;
        m_out[cs][cx]  = co;
      end else e_err = 1;
    end
    @(posedge clk);
    #1;
    chk("state", int'(state), m_state);
    chk("out", int'(out), m_o);
    chk("step_vld", int'(step_vld), e_step);
    chk("err", int'(err), e_err);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    sw_in = '0; ctrl_in = 1'b0; load_en = 1'b0; state_in = '0;
    cfg_we = 1'b0; cfg_state = '0; cfg_sym = '0; cfg_next = '0; cfg_out = '0;
    m_reset();
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_step", int'(step_vld), 0);
    chk("rst_err", int'(err), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Unprogrammed table holds state.
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0, 0, 0, 0);
    chk("selfloop_state", int'(state), 3);
    idle();

    // Programmed transitions.
    cyc(0, 0, 0, 0, 1, 0, 1, 4, 1);
    cyc(0, 0, 0, 0, 1, 4, 3, 2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("prog_s4", int'(state), 4);
    chk("prog_o1", int'(out), 1);
    cyc(0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("prog_s2", int'(state), 2);

    // Illegal write (next=5) rejected; entry [1][2] stays a self-loop.
    cyc(0, 0, 0, 0, 1, 1, 2, 5, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0, 0, 0, 0);
    chk("readback_s1", int'(state), 1);

    // Write and step on the same entry: old entry first, new one after.
    cyc(1, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 2, 0, 1, 1);
    chk("old_entry", int'(state), 2);
    cyc(1, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("new_entry", int'(state), 1);

    // Load beats step; illegal load; illegal load plus illegal write.
    cyc(1, 4, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 1, 6, 0, 0, 0);
    idle();

    // Async reset between edges clears state and table.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("async_state", int'(state), 0);
    chk("async_out", int'(out), 0);
    #3 reset_n = 1'b1;
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("cleared_tbl", int'(state), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 8) == 0 ? 1 : 0, $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 3),
          ($urandom % 3) == 0 ? 1 : 0, $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
